// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS core: valid/ready request, byte-enabled word RAM, fixed-latency response.
// Optional `DMEM_ALIGN_CHECK_EN flags misaligned or out-of-range addresses through rsp_err.
module mips_dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] idx_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          err_q;
    logic          req_err;
    logic          commit;
    logic [31:0]   mem [DEPTH_WORDS];

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
    assign req_err = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign commit    = (state == BUSY) && (cnt == '0);

    // Every accept passes through BUSY so the response lands LATENCY edges after accept,
    // including LATENCY == 1 where the counter starts at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        idx_q   <= req_addr[AW+1:2];
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        err_q   <= req_err;
                        cnt     <= CNT_INIT;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                        rsp_rdata <= (we_q || err_q) ? 32'h0 : mem[idx_q];
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM is deliberately outside the reset domain; a store commits only on the edge entering RESP.
    always_ff @(posedge clock) begin
        if (!reset && commit && we_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule
